// File: rtl/voting_ballot_packer_if.sv
// -----------------------------------------------------------------------------
// voting_ballot_packer_if
// Bundles the ballot input stream and the packed-frame output stream of
// voting_ballot_packer.
//   vote_valid/vote_bit/vote_ready : ballot handshake (packer is the sink)
//   close                          : request to end the session early
//   frame_valid/frame_ready        : frame handshake (packer is the source)
//   frame_data[15:0]               : bit 0 session flag, bit k = ballot k-1
//   frame_count[3:0]               : ballots packed into the current frame
//   yes_count[3:0]/majority        : tally outputs, only with VOTING_TALLY_EN
// Modport master is the packer side; modport slave is the surrounding logic.
// Optional feature macro: VOTING_TALLY_EN
// -----------------------------------------------------------------------------
interface voting_ballot_packer_if;
   logic        vote_valid;
   logic        vote_bit;
   logic        vote_ready;
   logic        close;
   logic        frame_valid;
   logic        frame_ready;
   logic [15:0] frame_data;
   logic [3:0]  frame_count;
`ifdef VOTING_TALLY_EN
   logic [3:0]  yes_count;
   logic        majority;

   modport master (
      input  vote_valid, vote_bit, close, frame_ready,
      output vote_ready, frame_valid, frame_data, frame_count, yes_count, majority
   );
   modport slave (
      output vote_valid, vote_bit, close, frame_ready,
      input  vote_ready, frame_valid, frame_data, frame_count, yes_count, majority
   );
`else
   modport master (
      input  vote_valid, vote_bit, close, frame_ready,
      output vote_ready, frame_valid, frame_data, frame_count
   );
   modport slave (
      output vote_valid, vote_bit, close, frame_ready,
      input  vote_ready, frame_valid, frame_data, frame_count
   );
`endif
endinterface

// File: rtl/voting_ballot_packer.sv
// -----------------------------------------------------------------------------
// voting_ballot_packer
// Collects single-bit ballots into a 16-bit frame and hands the frame to a
// downstream voting circuit.  A frame closes when MAX_VOTERS ballots have been
// accepted or when close is seen; it is then held until frame_ready.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset, discards any partial/pending frame
//   bus   : voting_ballot_packer_if.master (ballot input, frame output)
// Parameter:
//   MAX_VOTERS : ballots per frame, 1..15
// Optional feature macro: VOTING_TALLY_EN adds yes_count and majority.
// -----------------------------------------------------------------------------
module voting_ballot_packer #(
   parameter int MAX_VOTERS = 15
) (
   input logic                    clk,
   input logic                    rst_n,
   voting_ballot_packer_if.master bus
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_VOTERS);

   typedef enum logic {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [15:0] data_r;
   logic [3:0]  count_r;
   logic [3:0]  next_count_s;
   logic        accept_s;
   logic        last_s;
   logic        handshake_s;

   assign accept_s     = bus.vote_valid & (state_r == COLLECT);
   assign next_count_s = count_r + 4'd1;
   assign last_s       = (next_count_s == MAX_CNT);
   assign handshake_s  = (state_r == EMIT) & bus.frame_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= COLLECT;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic: a ballot accepted alongside close is still packed,
   // because the datapath takes it on the same edge the state moves to EMIT
   always_comb begin
      state_s = state_r;
      case (state_r)
         COLLECT: begin
            if (bus.close || (accept_s && last_s)) begin
               state_s = EMIT;
            end else begin
               state_s = COLLECT;
            end
         end
         EMIT: begin
            if (bus.frame_ready) begin
               state_s = COLLECT;
            end else begin
               state_s = EMIT;
            end
         end
         default: state_s = COLLECT;
      endcase
   end

   // Frame datapath: bit 0 marks a non-empty session, ballot n lands in bit n+1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r  <= 16'h0000;
         count_r <= 4'd0;
      end else if (handshake_s) begin
         data_r  <= 16'h0000;
         count_r <= 4'd0;
      end else if (accept_s) begin
         data_r[next_count_s] <= bus.vote_bit;
         data_r[0]            <= 1'b1;
         count_r              <= next_count_s;
      end else begin
         data_r  <= data_r;
         count_r <= count_r;
      end
   end

   assign bus.vote_ready  = (state_r == COLLECT);
   assign bus.frame_valid = (state_r == EMIT);
   assign bus.frame_data  = data_r;
   assign bus.frame_count = count_r;

`ifdef VOTING_TALLY_EN
   logic [3:0] yes_r;
   logic [3:0] yes_next_s;
   logic       majority_r;

   assign yes_next_s = yes_r + {3'd0, bus.vote_bit};

   // Running yes tally; majority is precomputed with the post-accept counts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         yes_r      <= 4'd0;
         majority_r <= 1'b0;
      end else if (handshake_s) begin
         yes_r      <= 4'd0;
         majority_r <= 1'b0;
      end else if (accept_s) begin
         yes_r      <= yes_next_s;
         majority_r <= ({yes_next_s, 1'b0} > {1'b0, next_count_s});
      end else begin
         yes_r      <= yes_r;
         majority_r <= majority_r;
      end
   end

   assign bus.yes_count = yes_r;
   assign bus.majority  = majority_r;
`endif

endmodule
